// File: rtl/fetch_prefetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fetch_prefetch                                                   |
// | Purpose : PC owner and in-order instruction prefetcher with a DEPTH-entry  |
// |           buffer, flushed on start / branch (optional FETCH_ABS_JUMP_EN).  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module fetch_prefetch #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_address_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_off_i,
`ifdef FETCH_ABS_JUMP_EN
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
`endif
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] pc_o,
  input  logic              ready_i
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w:0] c_depth = (c_cnt_w+1)'(DEPTH);
  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_run  = 1'b1;

  logic [0:0]         r_state;
  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [ADDR_W-1:0]  r_resp_pc;
  logic [c_cnt_w-1:0] r_wr_ptr;
  logic [c_cnt_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_outstanding;
  logic [c_cnt_w-1:0] r_discard;
  logic [DATA_W-1:0]  r_fifo_instr [DEPTH];
  logic [ADDR_W-1:0]  r_fifo_pc    [DEPTH];

  logic [c_cnt_w-1:0] w_occ;
  logic [c_ptr_w-1:0] w_rd_idx;
  logic [c_ptr_w-1:0] w_wr_idx;
  logic [c_cnt_w:0]   w_credit;
  logic [c_cnt_w-1:0] w_out_next;
  logic [ADDR_W-1:0]  w_target;
  logic               w_fire;
  logic               w_branch;
  logic               w_redirect;
  logic               w_gnt;
  logic               w_resp;
  logic               w_push;
  logic               w_pop;

  assign w_occ    = r_wr_ptr - r_rd_ptr;
  assign w_rd_idx = r_rd_ptr[c_ptr_w-1:0];
  assign w_wr_idx = r_wr_ptr[c_ptr_w-1:0];

  assign valid_o = (w_occ != '0);
  assign instr_o = valid_o ? r_fifo_instr[w_rd_idx] : '0;
  assign pc_o    = valid_o ? r_fifo_pc[w_rd_idx]    : '0;

  assign w_fire   = valid_o & ready_i;
  assign w_branch = branch_i & w_fire;

`ifdef FETCH_ABS_JUMP_EN
  logic w_jump;
  assign w_jump     = jump_i & w_fire;
  assign w_redirect = start_i | w_jump | w_branch;
`else
  assign w_redirect = start_i | w_branch;
`endif

  always_comb begin
    w_target = r_fetch_pc;
    if (start_i)
      w_target = start_address_i;
`ifdef FETCH_ABS_JUMP_EN
    else if (w_jump)
      w_target = jump_addr_i;
`endif
    else if (w_branch)
      w_target = pc_o + branch_off_i;
  end

  // Buffered plus in-flight words never exceed DEPTH, so every response has a slot.
  assign w_credit    = {1'b0, w_occ} + {1'b0, r_outstanding};
  assign imem_req_o  = (r_state == c_st_run) && (w_credit < c_depth) && !w_redirect;
  assign imem_addr_o = r_fetch_pc;

  assign w_gnt      = imem_req_o & imem_gnt_i;
  // With nothing outstanding (e.g. after reset) a response cannot be ours.
  assign w_resp     = imem_rvalid_i && (r_outstanding != '0);
  assign w_out_next = r_outstanding + c_cnt_w'(w_gnt) - c_cnt_w'(w_resp);
  assign w_push     = w_resp && (r_discard == '0) && !w_redirect;
  assign w_pop      = w_fire && !w_redirect;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_state       <= c_st_idle;
      r_fetch_pc    <= '0;
      r_resp_pc     <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (w_redirect) begin
        r_state    <= c_st_run;
        r_fetch_pc <= w_target;
        r_resp_pc  <= w_target;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_discard  <= w_out_next;
      end else begin
        if (w_gnt)
          r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
        if (w_resp) begin
          if (r_discard != '0)
            r_discard <= r_discard - c_cnt_w'(1);
          else
            r_resp_pc <= r_resp_pc + ADDR_W'(1);
        end
        if (w_push)
          r_wr_ptr <= r_wr_ptr + c_cnt_w'(1);
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + c_cnt_w'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_instr[w_wr_idx] <= imem_rdata_i;
      r_fifo_pc[w_wr_idx]    <= r_resp_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_fetch_prefetch                                                |
// | Purpose : directed self-checking bench for fetch_prefetch                  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_fetch_prefetch;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  start_address_i = 8'h00;
  logic        branch_i = 1'b0;
  logic [7:0]  branch_off_i = 8'h00;
`ifdef FETCH_ABS_JUMP_EN
  logic        jump_i = 1'b0;
  logic [7:0]  jump_addr_i = 8'h00;
`endif
  logic        imem_req_o;
  logic [7:0]  imem_addr_o;
  logic        imem_gnt_i = 1'b1;
  logic        imem_rvalid_i;
  logic [15:0] imem_rdata_i;
  logic        valid_o;
  logic [15:0] instr_o;
  logic [7:0]  pc_o;
  logic        ready_i = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int gnt_cnt = 0;

  // Memory model: latency = lat_idx + 1 cycles, word = {~addr, addr}.
  logic [1:0] lat_idx = 2'd0;
  logic [3:0] pv = 4'b0;
  logic [7:0] pa [4];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pv    <= {pv[2:0], imem_req_o & imem_gnt_i};
    pa[0] <= imem_addr_o;
    pa[1] <= pa[0];
    pa[2] <= pa[1];
    pa[3] <= pa[2];
    if (imem_req_o && imem_gnt_i) gnt_cnt <= gnt_cnt + 1;
  end

  assign imem_rvalid_i = pv[lat_idx];
  assign imem_rdata_i  = {~pa[lat_idx], pa[lat_idx]};

  fetch_prefetch #(.ADDR_W(8), .DATA_W(16), .DEPTH(4)) dut (
    .clk(clk), .rst_i(rst_i),
    .start_i(start_i), .start_address_i(start_address_i),
    .branch_i(branch_i), .branch_off_i(branch_off_i),
`ifdef FETCH_ABS_JUMP_EN
    .jump_i(jump_i), .jump_addr_i(jump_addr_i),
`endif
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .valid_o(valid_o), .instr_o(instr_o), .pc_o(pc_o), .ready_i(ready_i)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(output bit ok);
    for (int i = 0; i < 20 && !valid_o; i++) tick();
    ok = valid_o;
  endtask

  task automatic apply_reset(input logic [1:0] lat);
    rst_i = 1'b1; start_i = 1'b0; branch_i = 1'b0; ready_i = 1'b0;
`ifdef FETCH_ABS_JUMP_EN
    jump_i = 1'b0;
`endif
    tick(); tick();
    rst_i = 1'b0;
    repeat (5) tick();
    lat_idx = lat;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(); tick();
    vectors++; if (imem_req_o !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b want 0", imem_req_o); end
    vectors++; if (imem_addr_o !== 8'h00) begin miscompares++; $display("FAIL rst_addr: got %h want 00", imem_addr_o); end
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", valid_o); end
    vectors++; if ({instr_o, pc_o} !== 24'h0) begin miscompares++; $display("FAIL rst_head: got %h/%h want 0000/00", instr_o, pc_o); end
    rst_i = 1'b0;
    repeat (4) tick();
    vectors++; if (imem_req_o !== 1'b0) begin miscompares++; $display("FAIL idle_req: got %b want 0", imem_req_o); end
  endtask

  task automatic test_stream();
    apply_reset(2'd0);
    ready_i = 1'b1; start_i = 1'b1; start_address_i = 8'h10;
    tick();
    start_i = 1'b0; #1;
    vectors++; if ({imem_req_o, imem_addr_o} !== {1'b1, 8'h10}) begin miscompares++; $display("FAIL t1_req: got %b/%h want 1/10", imem_req_o, imem_addr_o); end
    tick();
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL t1_latency: valid got %b want 0", valid_o); end
    tick();
    vectors++; if ({valid_o, pc_o, instr_o} !== {1'b1, 8'h10, 16'hEF10}) begin miscompares++; $display("FAIL t1_first: got %b/%h/%h want 1/10/ef10", valid_o, pc_o, instr_o); end
    for (int k = 1; k <= 5; k++) begin
      logic [7:0] epc;
      epc = 8'h10 + 8'(k);
      tick();
      vectors++; if ({valid_o, pc_o, instr_o} !== {1'b1, epc, ~epc, epc}) begin miscompares++; $display("FAIL t1_b2b: got %b/%h/%h want 1/%h/%h", valid_o, pc_o, instr_o, epc, {~epc, epc}); end
    end
  endtask

  task automatic test_backpressure();
    int g0;
    apply_reset(2'd0);
    ready_i = 1'b0; start_i = 1'b1; start_address_i = 8'h40;
    g0 = gnt_cnt;
    tick();
    start_i = 1'b0;
    repeat (12) tick();
    vectors++; if (gnt_cnt - g0 !== 4) begin miscompares++; $display("FAIL t2_gnts: got %0d want 4", gnt_cnt - g0); end
    vectors++; if ({imem_req_o, imem_addr_o} !== {1'b0, 8'h44}) begin miscompares++; $display("FAIL t2_stall: got %b/%h want 0/44", imem_req_o, imem_addr_o); end
    vectors++; if ({valid_o, pc_o} !== {1'b1, 8'h40}) begin miscompares++; $display("FAIL t2_head: got %b/%h want 1/40", valid_o, pc_o); end
    ready_i = 1'b1;
    tick();
    vectors++; if ({imem_req_o, imem_addr_o, pc_o} !== {1'b1, 8'h44, 8'h41}) begin miscompares++; $display("FAIL t2_resume: got %b/%h/%h want 1/44/41", imem_req_o, imem_addr_o, pc_o); end
  endtask

  task automatic test_branch_discard();
    bit found = 1'b0;
    bit ok;
    apply_reset(2'd1);
    ready_i = 1'b1; start_i = 1'b1; start_address_i = 8'h1C;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = valid_o && (pc_o == 8'h20);
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL t3_reach20: got pc %h want 20", pc_o); end
    branch_i = 1'b1; branch_off_i = 8'hFC;
    tick();
    branch_i = 1'b0;
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL t3_flush: valid got %b want 0", valid_o); end
    wait_valid(ok);
    vectors++; if (!ok || pc_o !== 8'h1C) begin miscompares++; $display("FAIL t3_target: got %b/%h want 1/1c", valid_o, pc_o); end
    tick();
    vectors++; if ({valid_o, pc_o} !== {1'b1, 8'h1D}) begin miscompares++; $display("FAIL t3_next: got %b/%h want 1/1d", valid_o, pc_o); end
  endtask

  task automatic test_wrap();
    bit ok;
    apply_reset(2'd0);
    ready_i = 1'b1; start_i = 1'b1; start_address_i = 8'hFE;
    tick();
    start_i = 1'b0;
    wait_valid(ok);
    vectors++; if (!ok || pc_o !== 8'hFE) begin miscompares++; $display("FAIL t4_fe: got %b/%h want 1/fe", valid_o, pc_o); end
    tick();
    vectors++; if ({valid_o, pc_o} !== {1'b1, 8'hFF}) begin miscompares++; $display("FAIL t4_ff: got %b/%h want 1/ff", valid_o, pc_o); end
    tick();
    vectors++; if ({valid_o, pc_o, instr_o} !== {1'b1, 8'h00, 16'hFF00}) begin miscompares++; $display("FAIL t4_wrap: got %b/%h/%h want 1/00/ff00", valid_o, pc_o, instr_o); end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_valid(ok);
    tick();
    vectors++; if ({valid_o, pc_o} !== {1'b1, 8'hFF}) begin miscompares++; $display("FAIL t4_ff2: got %b/%h want 1/ff", valid_o, pc_o); end
    branch_i = 1'b1; branch_off_i = 8'h05;
    tick();
    branch_i = 1'b0;
    wait_valid(ok);
    vectors++; if (!ok || pc_o !== 8'h04) begin miscompares++; $display("FAIL t4_btarget: got %b/%h want 1/04", valid_o, pc_o); end
    tick();
    vectors++; if ({valid_o, pc_o} !== {1'b1, 8'h05}) begin miscompares++; $display("FAIL t4_bnext: got %b/%h want 1/05", valid_o, pc_o); end
  endtask

  task automatic test_priority_and_reset();
    bit ok;
    apply_reset(2'd0);
    ready_i = 1'b1; start_i = 1'b1; start_address_i = 8'h50;
    tick();
    start_i = 1'b0;
    wait_valid(ok);
    tick();
    start_i = 1'b1; start_address_i = 8'h60; branch_i = 1'b1; branch_off_i = 8'h10;
    tick();
    start_i = 1'b0; branch_i = 1'b0;
    wait_valid(ok);
    vectors++; if (!ok || pc_o !== 8'h60) begin miscompares++; $display("FAIL t5_startwins: got %b/%h want 1/60", valid_o, pc_o); end
    tick(); tick();
    rst_i = 1'b1;
    tick();
    vectors++; if ({valid_o, imem_req_o, pc_o, imem_addr_o, instr_o} !== 34'h0) begin miscompares++; $display("FAIL t5_rst: got v%b r%b pc%h a%h i%h want all 0", valid_o, imem_req_o, pc_o, imem_addr_o, instr_o); end
    rst_i = 1'b0;
    repeat (3) tick();
    vectors++; if ({valid_o, imem_req_o} !== 2'b00) begin miscompares++; $display("FAIL t5_idle: got v%b r%b want 0/0", valid_o, imem_req_o); end
  endtask

`ifdef FETCH_ABS_JUMP_EN
  task automatic test_jump();
    bit found = 1'b0;
    bit ok;
    apply_reset(2'd0);
    ready_i = 1'b1; start_i = 1'b1; start_address_i = 8'h2E;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = valid_o && (pc_o == 8'h30);
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL t6_reach30: got pc %h want 30", pc_o); end
    jump_i = 1'b1; jump_addr_i = 8'h80; branch_i = 1'b1; branch_off_i = 8'h10;
    tick();
    jump_i = 1'b0; branch_i = 1'b0;
    wait_valid(ok);
    vectors++; if (!ok || pc_o !== 8'h80) begin miscompares++; $display("FAIL t6_jump: got %b/%h want 1/80", valid_o, pc_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_branch_discard();
    test_wrap();
    test_priority_and_reset();
`ifdef FETCH_ABS_JUMP_EN
    test_jump();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
